// File: rtl/line_clear_engine.sv
// Sequential line-clear stage: latches a WIDTH x HEIGHT occupancy field, scans it
// bottom to top one row per cycle, drops full rows and compacts the rest downward.
module line_clear_engine #(
    parameter int WIDTH      = 20,
    parameter int HEIGHT     = 20,
    parameter int SCORE_MODE = 0,
    parameter int SCORE_W    = 16,
    localparam int CW        = $clog2(HEIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [0:WIDTH*HEIGHT-1]   field_in,
    input  logic                      score_clr,
    output logic                      busy,
    output logic                      done,
    output logic [0:WIDTH*HEIGHT-1]   field_out,
    output logic [CW-1:0]             lines_cleared,
    output logic [0:HEIGHT-1]         cleared_rows,
    output logic [SCORE_W-1:0]        score,
    output logic [1:0]                state_dbg
);

    // Handshake: start is taken only in IDLE (including the cycle done is high);
    // done is a one-cycle pulse and the result outputs hold until the next accepted start.

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   src  [HEIGHT];
    logic [WIDTH-1:0]   work [HEIGHT];
    logic [RW-1:0]      rd;
    logic [RW-1:0]      wr;
    logic [CW-1:0]      count;
    logic [0:HEIGHT-1]  mask;

    logic [SCORE_W-1:0] points;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_next;

    assign state_dbg = state;

    // One extra carry bit lets the accumulator saturate instead of wrapping.
    always_comb begin
        if (SCORE_MODE == 1) begin
            points = SCORE_W'(count) * SCORE_W'(count);
        end else begin
            points = SCORE_W'(count);
        end
        sum        = {1'b0, score} + {1'b0, points};
        score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            field_out     <= '0;
            lines_cleared <= '0;
            cleared_rows  <= '0;
            score         <= '0;
            rd            <= '0;
            wr            <= '0;
            count         <= '0;
            mask          <= '0;
            for (int r = 0; r < HEIGHT; r++) begin
                src[r]  <= '0;
                work[r] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (score_clr) begin
                score <= '0;
            end else if (state == FINISH) begin
                score <= score_next;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < HEIGHT; r++) begin
                            src[r]  <= field_in[r*WIDTH +: WIDTH];
                            work[r] <= '0;
                        end
                        rd    <= LAST_ROW;
                        wr    <= LAST_ROW;
                        count <= '0;
                        mask  <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    // Rows never written here stay zero and become the refilled top.
                    if (&src[rd]) begin
                        mask[rd] <= 1'b1;
                        count    <= count + 1'b1;
                    end else begin
                        work[wr] <= src[rd];
                        wr       <= wr - 1'b1;
                    end
                    if (rd == '0) begin
                        state <= FINISH;
                    end else begin
                        rd <= rd - 1'b1;
                    end
                end

                FINISH: begin
                    for (int r = 0; r < HEIGHT; r++) begin
                        field_out[r*WIDTH +: WIDTH] <= work[r];
                    end
                    lines_cleared <= count;
                    cleared_rows  <= mask;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: table vectors, randomized fields against a queue-based
// row model, and hand-written sequences for reset, interruption, back-to-back and scoring.
`timescale 1ns/1ps
module tb_line_clear_engine;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam int N  = W * H;
    localparam int CW = 5;
    localparam int SW = 16;
    localparam int SH = 6;
    localparam int SN = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic           start, score_clr, busy, done;
    logic [0:N-1]   field_in, field_out;
    logic [CW-1:0]  lines_cleared;
    logic [0:H-1]   cleared_rows;
    logic [SW-1:0]  score;
    logic [1:0]     state_dbg;

    logic           q_start, q_clr, q_busy, q_done;
    logic [0:N-1]   q_field, q_field_out;
    logic [CW-1:0]  q_lines;
    logic [0:H-1]   q_rows;
    logic [SW-1:0]  q_score;
    logic [1:0]     q_state;

    logic           s_start, s_clr, s_busy, s_done;
    logic [0:SN-1]  s_field, s_field_out;
    logic [2:0]     s_lines;
    logic [0:SH-1]  s_rows;
    logic [3:0]     s_score;
    logic [1:0]     s_state;

    line_clear_engine #(.WIDTH(W), .HEIGHT(H), .SCORE_MODE(0), .SCORE_W(SW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .field_in(field_in), .score_clr(score_clr),
        .busy(busy), .done(done), .field_out(field_out), .lines_cleared(lines_cleared),
        .cleared_rows(cleared_rows), .score(score), .state_dbg(state_dbg)
    );

    line_clear_engine #(.WIDTH(W), .HEIGHT(H), .SCORE_MODE(1), .SCORE_W(SW)) dut_q (
        .clk(clk), .resetn(resetn), .start(q_start), .field_in(q_field), .score_clr(q_clr),
        .busy(q_busy), .done(q_done), .field_out(q_field_out), .lines_cleared(q_lines),
        .cleared_rows(q_rows), .score(q_score), .state_dbg(q_state)
    );

    line_clear_engine #(.WIDTH(8), .HEIGHT(SH), .SCORE_MODE(1), .SCORE_W(4)) dut_s (
        .clk(clk), .resetn(resetn), .start(s_start), .field_in(s_field), .score_clr(s_clr),
        .busy(s_busy), .done(s_done), .field_out(s_field_out), .lines_cleared(s_lines),
        .cleared_rows(s_rows), .score(s_score), .state_dbg(s_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int score_m  = 0;

    logic [0:N-1] exp_q[$];
    int           exp_n_q[$];
    logic [0:H-1] exp_m_q[$];

    typedef struct {
        logic [0:N-1] field;
        logic [0:N-1] exp_field;
        int           exp_lines;
        logic [0:H-1] exp_mask;
        int           exp_score;
    } vec_t;
    vec_t vecs[6];

    task automatic check_int(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_field(input string name, input logic [0:N-1] act, input logic [0:N-1] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [0:N-1] rand_field(input int pct);
        logic [0:N-1] f;
        for (int r = 0; r < H; r++) begin
            if (int'($urandom_range(0, 99)) < pct) f[r*W +: W] = '1;
            else f[r*W +: W] = W'($urandom);
        end
        return f;
    endfunction

    // Full rows vanish; survivors keep their order and stack from the bottom up.
    function automatic void model(input logic [0:N-1] f, output logic [0:N-1] o,
                                  output int n, output logic [0:H-1] m);
        logic [W-1:0] kept[$];
        logic [W-1:0] row;
        o = '0;
        n = 0;
        m = '0;
        for (int r = H - 1; r >= 0; r--) begin
            row = f[r*W +: W];
            if (row == {W{1'b1}}) begin
                n++;
                m[r] = 1'b1;
            end else begin
                kept.push_back(row);
            end
        end
        for (int i = 0; i < kept.size(); i++) o[(H-1-i)*W +: W] = kept[i];
    endfunction

    task automatic push_exp(input logic [0:N-1] o, input int n, input logic [0:H-1] m);
        exp_q.push_back(o);
        exp_n_q.push_back(n);
        exp_m_q.push_back(m);
    endtask

    task automatic push_model(input logic [0:N-1] f);
        logic [0:N-1] o;
        int n;
        logic [0:H-1] m;
        model(f, o, n, m);
        push_exp(o, n, m);
    endtask

    task automatic drive_start(input logic [0:N-1] f);
        @(negedge clk);
        field_in = f;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        field_in = rand_field(50);
        check_int("busy_after_start", busy, 1);
    endtask

    task automatic check_result(input string name);
        logic [0:N-1] o;
        int n;
        logic [0:H-1] m;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: got empty queue, expected a pending result", name);
            return;
        end
        o = exp_q.pop_front();
        n = exp_n_q.pop_front();
        m = exp_m_q.pop_front();
        score_m = sat16(score_m + n);
        check_int({name, "_done"}, done, 1);
        check_int({name, "_busy"}, busy, 0);
        check_field({name, "_field"}, field_out, o);
        check_int({name, "_lines"}, lines_cleared, n);
        check_int({name, "_rows"}, cleared_rows, m);
        check_int({name, "_score"}, score, score_m);
    endtask

    task automatic wait_done(input string name, input int elapsed);
        int cyc;
        cyc = elapsed;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_int({name, "_latency"}, cyc, H + 1);
        check_result(name);
        @(posedge clk);
        #1;
        check_int({name, "_pulse"}, done, 0);
    endtask

    initial begin
        logic [0:N-1] f;
        logic [0:N-1] zero_f;
        logic [0:SN-1] s_exp;
        int cnt;
        int cyc;
        int exp_s[3];

        exp_s  = '{9, 15, 0};
        zero_f = '0;

        for (int i = 0; i < 6; i++) begin
            vecs[i].field     = '0;
            vecs[i].exp_field = '0;
            vecs[i].exp_mask  = '0;
        end
        vecs[0].field[19*W +: W] = '1;
        vecs[0].field[18*W +: W] = 20'h00001;
        vecs[0].field[17*W +: W] = '1;
        vecs[0].field[16*W +: W] = 20'h80000;
        vecs[0].exp_field[19*W +: W] = 20'h00001;
        vecs[0].exp_field[18*W +: W] = 20'h80000;
        vecs[0].exp_lines = 2;
        vecs[0].exp_mask[17] = 1'b1;
        vecs[0].exp_mask[19] = 1'b1;
        vecs[0].exp_score = 2;
        for (int r = 0; r < H; r++) begin
            vecs[1].field[r*W +: W]     = 20'h0F0F0 ^ W'(r);
            vecs[1].exp_field[r*W +: W] = 20'h0F0F0 ^ W'(r);
        end
        vecs[1].exp_lines = 0;
        vecs[1].exp_score = 2;
        vecs[2].field     = '1;
        vecs[2].exp_lines = 20;
        vecs[2].exp_mask  = '1;
        vecs[2].exp_score = 22;
        for (int r = 0; r < H; r++) begin
            if (r % 2 == 0) begin
                vecs[3].field[r*W +: W] = '1;
                vecs[3].exp_mask[r] = 1'b1;
            end else begin
                vecs[3].field[r*W +: W] = 20'h12345 + W'(r);
            end
        end
        for (int i = 0; i < 10; i++) vecs[3].exp_field[(19-i)*W +: W] = 20'h12345 + W'(19 - 2*i);
        vecs[3].exp_lines = 10;
        vecs[3].exp_score = 32;
        vecs[4].field[0 +: W] = '1;
        for (int r = 1; r < H; r++) begin
            vecs[4].field[r*W +: W]     = W'(r);
            vecs[4].exp_field[r*W +: W] = W'(r);
        end
        vecs[4].exp_lines = 1;
        vecs[4].exp_mask[0] = 1'b1;
        vecs[4].exp_score = 33;
        for (int r = 0; r < H - 1; r++) vecs[5].field[r*W +: W] = 20'hFFFFE;
        vecs[5].field[19*W +: W] = '1;
        for (int r = 1; r < H; r++) vecs[5].exp_field[r*W +: W] = 20'hFFFFE;
        vecs[5].exp_lines = 1;
        vecs[5].exp_mask[19] = 1'b1;
        vecs[5].exp_score = 34;

        // clock/reset
        resetn = 1'b0; start = 1'b0; score_clr = 1'b0; field_in = '0;
        q_start = 1'b0; q_clr = 1'b0; q_field = '0;
        s_start = 1'b0; s_clr = 1'b0; s_field = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_busy", busy, 0);
        check_int("rst_done", done, 0);
        check_field("rst_field", field_out, zero_f);
        check_int("rst_lines", lines_cleared, 0);
        check_int("rst_rows", cleared_rows, 0);
        check_int("rst_score", score, 0);
        check_int("rst_state", state_dbg, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive_start(vecs[i].field);
            push_exp(vecs[i].exp_field, vecs[i].exp_lines, vecs[i].exp_mask);
            wait_done($sformatf("vec%0d", i), 0);
            check_int($sformatf("vec%0d_tbl_score", i), score, vecs[i].exp_score);
        end

        for (int k = 0; k < 25; k++) begin
            f = rand_field(int'($urandom_range(0, 70)));
            drive_start(f);
            push_model(f);
            wait_done($sformatf("rand%0d", k), 0);
        end

        f = rand_field(40);
        drive_start(f);
        push_model(f);
        repeat (5) begin @(posedge clk); #1; end
        score_clr = 1'b1;
        @(posedge clk);
        #1;
        score_clr = 1'b0;
        score_m = 0;
        check_int("clr_mid_scan_score", score, 0);
        check_int("clr_mid_scan_busy", busy, 1);
        wait_done("clr_scan", 6);

        f = rand_field(40);
        drive_start(f);
        push_model(f);
        for (int k = 1; k <= 10; k++) begin
            field_in = rand_field(40);
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done("interrupt", 10);
        cnt = 0;
        repeat (30) begin @(posedge clk); #1; if (done) cnt++; end
        check_int("interrupt_extra_done", cnt, 0);

        f = rand_field(30);
        drive_start(f);
        repeat (4) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_int("midrst_busy", busy, 0);
        check_int("midrst_done", done, 0);
        check_field("midrst_field", field_out, zero_f);
        check_int("midrst_lines", lines_cleared, 0);
        check_int("midrst_rows", cleared_rows, 0);
        check_int("midrst_score", score, 0);
        resetn = 1'b1;
        score_m = 0;
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (done) cnt++; end
        check_int("midrst_no_done", cnt, 0);
        check_int("midrst_idle_busy", busy, 0);

        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            @(negedge clk);
            f = rand_field(40);
            field_in = f;
            push_model(f);
            @(posedge clk);
            #1;
            for (int j = 1; j <= H + 1; j++) begin
                @(negedge clk);
                field_in = rand_field(40);
                @(posedge clk);
                #1;
                if (j == H + 1) begin
                    if (op == 2) start = 1'b0;
                    check_result($sformatf("b2b%0d", op));
                end else begin
                    check_int($sformatf("b2b%0d_quiet", op), done, 0);
                end
            end
        end
        @(posedge clk);
        #1;
        check_int("b2b_end_done", done, 0);
        check_int("b2b_end_busy", busy, 0);

        q_field = '1;
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            q_start = 1'b1;
            @(posedge clk);
            #1;
            q_start = 1'b0;
            cyc = 0;
            while (q_done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            check_int($sformatf("quad%0d_latency", op), cyc, H + 1);
            check_field($sformatf("quad%0d_field", op), q_field_out, zero_f);
            check_int($sformatf("quad%0d_lines", op), q_lines, 20);
            check_int($sformatf("quad%0d_rows", op), q_rows, 20'hFFFFF);
            check_int($sformatf("quad%0d_score", op), q_score, 400 * (op + 1));
        end

        s_field = {8'hFF, 8'h01, 8'hFF, 8'h02, 8'hFF, 8'h03};
        s_exp   = {8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        for (int op = 0; op < 3; op++) begin
            @(negedge clk);
            s_start = 1'b1;
            @(posedge clk);
            #1;
            s_start = 1'b0;
            cyc = 0;
            while (s_done !== 1'b1 && cyc < 200) begin
                if (op == 2 && cyc == SH) s_clr = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                s_clr = 1'b0;
            end
            check_int($sformatf("sat%0d_latency", op), cyc, SH + 1);
            check_int($sformatf("sat%0d_field", op), s_field_out, s_exp);
            check_int($sformatf("sat%0d_lines", op), s_lines, 3);
            check_int($sformatf("sat%0d_rows", op), s_rows, 6'b101010);
            check_int($sformatf("sat%0d_score", op), s_score, exp_s[op]);
            if (op == 1) begin
                s_clr = 1'b1;
                @(posedge clk);
                #1;
                s_clr = 1'b0;
                check_int("sat_clr_in_done", s_score, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
